// File: rtl/assert_event_arbiter.sv
// Timestamped fail/cover event collector with round-robin arbitration
// onto a single valid/ready report port, gated by a global disable.
module assert_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int TS_W   = 16,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      disable_iff,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic [NUM_CH-1:0]         ev,
    output logic                      rpt_valid,
    input  logic                      rpt_ready,
    output logic [$clog2(NUM_CH)-1:0] rpt_ch,
    output logic [TS_W-1:0]           rpt_ts,
    output logic                      rpt_ovf,
    output logic [NUM_CH-1:0]         pending,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic [CNT_W-1:0]          total_cnt
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int PC_W = $clog2(NUM_CH + 1);

    typedef enum logic {
        S_IDLE,
        S_REPORT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TS_W-1:0]     r_ts;
    logic [NUM_CH-1:0]   r_pend;
    logic [NUM_CH-1:0]   r_ovf;
    logic [TS_W-1:0]     r_tsc [NUM_CH];
    logic [CH_W-1:0]     r_last;
    logic                r_valid;
    logic [CH_W-1:0]     r_rpt_ch;
    logic [TS_W-1:0]     r_rpt_ts;
    logic                r_rpt_ovf;
    logic [CNT_W-1:0]    r_drop;
    logic [CNT_W-1:0]    r_total;

    logic [NUM_CH-1:0]   w_pend_nxt;
    logic [NUM_CH-1:0]   w_ovf_nxt;
    logic [TS_W-1:0]     w_tsc_nxt [NUM_CH];
    logic [PC_W-1:0]     w_acc_n;
    logic [PC_W-1:0]     w_drop_n;
    logic                w_hs;
    logic                w_gnt_vld;
    logic [CH_W-1:0]     w_gnt;
    logic [CH_W-1:0]     w_idx;
    logic                w_valid_nxt;
    logic [CH_W-1:0]     w_ch_nxt;
    logic [TS_W-1:0]     w_rts_nxt;
    logic                w_rovf_nxt;
    logic [CH_W-1:0]     w_last_nxt;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [PC_W-1:0]  b
    );
        logic [CNT_W+PC_W-1:0] s;
        s = {{PC_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
        if (|s[CNT_W+PC_W-1:CNT_W]) return '1;
        return s[CNT_W-1:0];
    endfunction

    assign w_hs = (r_state == S_REPORT) && r_valid && rpt_ready;

    // A channel handshaken this cycle frees its slot, so a coincident event re-pends
    always_comb begin
        w_pend_nxt = r_pend;
        w_ovf_nxt  = r_ovf;
        w_tsc_nxt  = r_tsc;
        w_acc_n    = '0;
        w_drop_n   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (disable_iff) begin
                w_pend_nxt[i] = 1'b0;
                w_ovf_nxt[i]  = 1'b0;
                w_tsc_nxt[i]  = '0;
            end else if (ev[i] && ch_en[i]) begin
                if (!r_pend[i] || (w_hs && r_rpt_ch == CH_W'(i))) begin
                    w_pend_nxt[i] = 1'b1;
                    w_ovf_nxt[i]  = 1'b0;
                    w_tsc_nxt[i]  = r_ts;
                    w_acc_n       = w_acc_n + PC_W'(1);
                end else begin
                    w_ovf_nxt[i]  = 1'b1;
                    w_drop_n      = w_drop_n + PC_W'(1);
                end
            end else if (w_hs && r_rpt_ch == CH_W'(i)) begin
                w_pend_nxt[i] = 1'b0;
                w_ovf_nxt[i]  = 1'b0;
            end
        end
    end

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_idx     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = CH_W'((int'(r_last) + k) % NUM_CH);
            if (!w_gnt_vld && r_pend[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_ch_nxt    = r_rpt_ch;
        w_rts_nxt   = r_rpt_ts;
        w_rovf_nxt  = r_rpt_ovf;
        w_last_nxt  = r_last;
        unique case (r_state)
            S_IDLE: begin
                if (w_gnt_vld && !disable_iff) begin
                    w_ch_nxt    = w_gnt;
                    w_rts_nxt   = r_tsc[w_gnt];
                    w_rovf_nxt  = r_ovf[w_gnt];
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                if (w_hs) begin
                    w_last_nxt  = r_rpt_ch;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (disable_iff) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ts      <= '0;
            r_pend    <= '0;
            r_ovf     <= '0;
            r_last    <= CH_W'(NUM_CH - 1);
            r_valid   <= 1'b0;
            r_rpt_ch  <= '0;
            r_rpt_ts  <= '0;
            r_rpt_ovf <= 1'b0;
            r_drop    <= '0;
            r_total   <= '0;
            for (int i = 0; i < NUM_CH; i++) r_tsc[i] <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ts      <= r_ts + TS_W'(1);
            r_pend    <= w_pend_nxt;
            r_ovf     <= w_ovf_nxt;
            r_tsc     <= w_tsc_nxt;
            r_last    <= w_last_nxt;
            r_valid   <= w_valid_nxt;
            r_rpt_ch  <= w_ch_nxt;
            r_rpt_ts  <= w_rts_nxt;
            r_rpt_ovf <= w_rovf_nxt;
            r_drop    <= sat_add(r_drop, w_drop_n);
            r_total   <= sat_add(r_total, w_acc_n);
        end
    end

    assign rpt_valid = r_valid;
    assign rpt_ch    = r_rpt_ch;
    assign rpt_ts    = r_rpt_ts;
    assign rpt_ovf   = r_rpt_ovf;
    assign pending   = r_pend;
    assign drop_cnt  = r_drop;
    assign total_cnt = r_total;

endmodule

// File: tb/tb_assert_event_arbiter.sv
// Directed bench for assert_event_arbiter: expected reports are queued
// when events are driven and compared as the DUT presents them.
module tb_assert_event_arbiter;

    logic        clk;
    logic        rst;
    logic        disable_iff;
    logic [3:0]  ch_en;
    logic [3:0]  ev;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [1:0]  rpt_ch;
    logic [15:0] rpt_ts;
    logic        rpt_ovf;
    logic [3:0]  pending;
    logic [7:0]  drop_cnt;
    logic [7:0]  total_cnt;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] ts;
        logic        ovf;
    } rep_t;

    rep_t        sb[$];
    int          n_chk;
    int          n_fail;
    int          exp_total;
    int          exp_drop;
    int          m_last;
    logic [15:0] m_ts;
    logic [15:0] t0;
    logic [15:0] ta;
    logic [15:0] tb;

    assert_event_arbiter #(.NUM_CH(4), .TS_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .disable_iff(disable_iff),
        .ch_en(ch_en), .ev(ev),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_ch(rpt_ch), .rpt_ts(rpt_ts), .rpt_ovf(rpt_ovf),
        .pending(pending), .drop_cnt(drop_cnt), .total_cnt(total_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timestamp: free-running count since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) m_ts <= '0;
        else     m_ts <= m_ts + 16'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a report, compare against the queue head, then handshake
    task automatic expect_rpt(input string tag, input int maxw);
        rep_t e;
        int   w;
        w = 0;
        while (rpt_valid !== 1'b1 && w < maxw) begin
            tick();
            w++;
        end
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        chk({tag, "_valid"}, 32'(rpt_valid), 32'd1);
        if (rpt_valid === 1'b1) begin
            chk({tag, "_ch"},  32'(rpt_ch),  32'(e.ch));
            chk({tag, "_ts"},  32'(rpt_ts),  32'(e.ts));
            chk({tag, "_ovf"}, 32'(rpt_ovf), 32'(e.ovf));
            m_last = int'(e.ch);
        end
        rpt_ready = 1'b1;
        tick();
    endtask

    task automatic push(input int ch, input logic [15:0] ts, input logic ovf);
        rep_t e;
        e.ch  = 2'(ch);
        e.ts  = ts;
        e.ovf = ovf;
        sb.push_back(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; exp_total = 0; exp_drop = 0; m_last = 3;
        rst = 1'b1; disable_iff = 1'b0; ch_en = 4'hF; ev = 4'h0;
        rpt_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid",   32'(rpt_valid), 32'd0);
        chk("rst_pending", 32'(pending),   32'd0);
        chk("rst_total",   32'(total_cnt), 32'd0);
        chk("rst_drop",    32'(drop_cnt),  32'd0);
        chk("rst_ts",      32'(rpt_ts),    32'd0);
        rst = 1'b0;

        // Single event at ts=5, two-cycle latency
        repeat (5) tick();
        ev = 4'b0001; t0 = m_ts;
        chk("single_tsmodel", 32'(t0), 32'd5);
        tick(); ev = 4'h0;
        chk("single_pend", 32'(pending), 32'h1);
        chk("single_nv",   32'(rpt_valid), 32'd0);
        tick();
        push(0, t0, 1'b0); exp_total += 1;
        expect_rpt("single", 0);
        chk("single_total", 32'(total_cnt), 32'(exp_total));

        // Round-robin: all four in one cycle, starting after last grant
        ev = 4'hF; t0 = m_ts;
        tick(); ev = 4'h0;
        for (int k = 1; k <= 4; k++) push((m_last + k) % 4, t0, 1'b0);
        exp_total += 4;
        expect_rpt("rr0", 1);
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("rr_bubble%0d", k), 32'(rpt_valid), 32'd0);
            tick();
            expect_rpt($sformatf("rr%0d", k), 0);
        end
        chk("rr_total", 32'(total_cnt), 32'(exp_total));

        // Overflow on ch2 while ch0 is stalled in REPORT
        rpt_ready = 1'b0;
        ev = 4'b0001; t0 = m_ts; tick(); ev = 4'h0; tick();
        ev = 4'b0100; ta = m_ts; tick(); ev = 4'h0; tick();
        ev = 4'b0100; tick(); ev = 4'h0; tick();
        ev = 4'b0100; tick(); ev = 4'h0;
        exp_total += 2; exp_drop += 2;
        chk("ovf_drop",  32'(drop_cnt),  32'(exp_drop));
        chk("ovf_total", 32'(total_cnt), 32'(exp_total));
        chk("ovf_hold",  32'(rpt_ch),    32'd0);
        push(0, t0, 1'b0); push(2, ta, 1'b1);
        expect_rpt("ovf_c0", 0);
        tick();
        expect_rpt("ovf_c2", 0);
        chk("ovf_pend", 32'(pending), 32'd0);

        // Backpressure: held stable for 10 cycles, then exactly one report
        rpt_ready = 1'b0;
        ev = 4'b0010; tb = m_ts; tick(); ev = 4'h0; tick();
        exp_total += 1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_v%0d", k),  32'(rpt_valid), 32'd1);
            chk($sformatf("bp_c%0d", k),  32'(rpt_ch),    32'd1);
            chk($sformatf("bp_t%0d", k),  32'(rpt_ts),    32'(tb));
            chk($sformatf("bp_o%0d", k),  32'(rpt_ovf),   32'd0);
            tick();
        end
        push(1, tb, 1'b0);
        expect_rpt("bp", 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_once%0d", k), 32'(rpt_valid), 32'd0);
            tick();
        end
        chk("bp_total", 32'(total_cnt), 32'(exp_total));

        // Disable mid-report withdraws valid and ignores coincident events
        rpt_ready = 1'b0;
        ev = 4'b0010; tick(); ev = 4'h0; tick();
        exp_total += 1;
        chk("dis_v", 32'(rpt_valid), 32'd1);
        chk("dis_c", 32'(rpt_ch),    32'd1);
        disable_iff = 1'b1; ev = 4'hF;
        tick();
        disable_iff = 1'b0; ev = 4'h0;
        chk("dis_valid", 32'(rpt_valid), 32'd0);
        chk("dis_pend",  32'(pending),   32'd0);
        chk("dis_total", 32'(total_cnt), 32'(exp_total));
        chk("dis_drop",  32'(drop_cnt),  32'(exp_drop));
        tick();
        chk("dis_idle", 32'(rpt_valid), 32'd0);

        // ev[3] coincident with ch3 handshake re-pends with fresh ts, ovf=0
        ev = 4'b1000; t0 = m_ts; tick(); ev = 4'h0; tick();
        ev = 4'b1000; tick(); ev = 4'h0;
        exp_drop += 1;
        chk("co_drop", 32'(drop_cnt), 32'(exp_drop));
        push(3, t0, 1'b0);
        ev = 4'b1000; ta = m_ts;
        expect_rpt("co_first", 0);
        ev = 4'h0;
        chk("co_pend", 32'(pending), 32'h8);
        push(3, ta, 1'b0);
        expect_rpt("co_again", 1);

        // Async reset mid-REPORT clears outputs without a clock edge
        rpt_ready = 1'b0;
        ev = 4'b0001; tick(); ev = 4'h0; tick();
        chk("ar_pre", 32'(rpt_valid), 32'd1);
        #2; rst = 1'b1; #1;
        chk("ar_valid", 32'(rpt_valid), 32'd0);
        chk("ar_pend",  32'(pending),   32'd0);
        chk("ar_total", 32'(total_cnt), 32'd0);
        chk("ar_drop",  32'(drop_cnt),  32'd0);
        chk("ar_ts",    32'(rpt_ts),    32'd0);
        chk("ar_ch",    32'(rpt_ch),    32'd0);
        tick(); rst = 1'b0;
        m_last = 3;
        sb.delete();

        // Saturation: 300 accepted events on ch0
        rpt_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            ev = 4'b0001; t0 = m_ts; tick(); ev = 4'h0;
            push(0, t0, 1'b0);
            expect_rpt($sformatf("sat%0d", k), 3);
        end
        chk("sat_total", 32'(total_cnt), 32'd255);
        chk("sat_drop",  32'(drop_cnt),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/assert_event_arbiter.md
Name: assert_event_arbiter

Overview:
- Collects fail/cover events from NUM_CH property-checker channels and timestamps each one.
- Shares a single report port between the channels using round-robin arbitration and a valid/ready handshake.
- Applies a global disable-iff gate.
- Sits between the assertion checkers and the trace/log sink in the verification-support hierarchy.

Parameters:
NUM_CH, 4, number of checker channels (2..16)
TS_W, 16, timestamp counter width
CNT_W, 8, width of the saturating drop and total counters

Ports:
clk  input  1  single clock, all state updates on posedge
rst  input  1  asynchronous active-high reset
disable_iff  input  1  global disable; clears and blocks all pending events
ch_en  input  NUM_CH  per-channel enable mask
ev  input  NUM_CH  per-channel event strobe, sampled on posedge
rpt_valid  output  1  report available
rpt_ready  input  1  sink accepts report
rpt_ch  output  $clog2(NUM_CH)  channel id of report
rpt_ts  output  TS_W  timestamp captured when event was sampled
rpt_ovf  output  1  channel lost at least one event since its last report
pending  output  NUM_CH  registered pending vector
drop_cnt  output  CNT_W  total dropped events, saturating
total_cnt  output  CNT_W  total accepted events, saturating

Behaviour:
- Reset (async, rst=1):
  - All outputs, pending, per-channel ts/ovf registers, counters and ts counter go to 0.
  - FSM goes to IDLE.
  - last_grant goes to NUM_CH-1, so ch0 has first priority.
- Timestamp counter:
  - Increments every cycle with rst=0.
  - Wraps 2^TS_W-1 -> 0 with no flag.
- Capture (per channel i, each posedge, disable_iff=0):
  - Accept when ev[i] & ch_en[i].
  - Pending clear: set pending[i], latch ts_i = current ts, total_cnt += 1 (saturate at all-ones).
  - Pending set and not being handshaken this cycle: keep the original ts_i, set ovf_i, drop_cnt += 1 (saturate).
  - Pending[i] handshaken this same cycle: the new event re-pends with the new ts, ovf_i cleared, not counted as a drop.
  - Accepts from several channels in one cycle: total_cnt adds the popcount of those accepts, and drop_cnt adds the popcount of those drops, both saturating.
- Disable:
  - While disable_iff=1, no captures occur and counters hold.
  - pending, ovf_i and ts_i clear on the next posedge.
  - If in REPORT, rpt_valid drops on the next posedge and the FSM returns to IDLE, even without rpt_ready. This is the only permitted withdrawal of valid.
- FSM:
  - IDLE:
    - If pending has any bit set and disable_iff=0, grant the first set bit searching from (last_grant+1) mod NUM_CH upward with wrap.
    - Register rpt_ch/rpt_ts/rpt_ovf from the granted channel, set rpt_valid=1 and go to REPORT.
  - REPORT:
    - rpt_* are held stable while rpt_valid & !rpt_ready.
    - On rpt_valid & rpt_ready:
      - clear pending[gnt] and ovf_gnt, and set last_grant=gnt;
      - rpt_valid=0, return to IDLE.
  - Throughput: at most one report per 2 cycles (IDLE bubble is required).
- Latency: ev high at edge k -> pending bit visible after edge k -> rpt_valid high after edge k+1 (2 cycles) when the FSM is idle.
- ch_en deasserted while a channel is pending does not clear the pending bit; it only blocks new captures.

Test Plan:
- Single event: after reset, ev=4'b0001 for 1 cycle at ts=5, rpt_ready=1 -> rpt_valid high 2 cycles after the event, rpt_ch=0, rpt_ts=5, rpt_ovf=0, total_cnt=1.
- Round-robin: ev=4'b1111 in one cycle, rpt_ready=1 -> reports in order ch0,1,2,3, one every 2 cycles, all with equal rpt_ts, total_cnt=4.
- Overflow: ev[2] pulsed 3 times while rpt_ready=0 -> rpt_ts equals the first event's ts, rpt_ovf=1, drop_cnt=2; after the handshake, pending[2]=0.
- Backpressure: rpt_ready=0 for 10 cycles with a report valid -> rpt_ch/ts/ovf stable throughout, then exactly one report on rpt_ready=1.
- Disable mid-report: REPORT active on ch1 with rpt_ready=0, then disable_iff=1 for 1 cycle -> rpt_valid=0 and pending=0 next cycle, no handshake counted; ev during the disable is ignored and total_cnt is unchanged.
- Edge cases:
  - Async rst asserted mid-REPORT -> outputs 0 immediately.
  - ev[3] coincident with the handshake of ch3 -> ch3 re-pends with the new ts and ovf=0.
  - With CNT_W=8, 300 events -> total_cnt=255.
